// File: rtl/nvme_pcie_pkg.sv
// Shared NVMe/PCIe definitions: arbiter state encoding and RQ width defaults.
package nvme_pcie_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int RQ_DATA_WIDTH  = 128;
    localparam int RQ_TUSER_WIDTH = 62;

endpackage

// File: rtl/rq_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first request at or after ptr.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [PW-1:0]      index,
    output logic               any
);

    logic [PW-1:0] j;

    // Walk offsets from far to near so the closest request wins last.
    always_comb begin
        gnt   = '0;
        index = '0;
        j     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % NUM_SRC);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                index  = j;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rq_arbiter.sv
// Packet-level round-robin arbiter sharing the PCIe RQ AXI4-Stream port.
module rq_arbiter
    import nvme_pcie_pkg::*;
#(
    parameter int NUM_SRC             = 4,
    parameter int C_DATA_WIDTH        = RQ_DATA_WIDTH,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = RQ_TUSER_WIDTH
) (
    input  logic                                   user_clk,
    input  logic                                   user_reset_n,
    input  logic                                   user_lnk_up,
    input  logic [NUM_SRC*C_DATA_WIDTH-1:0]        src_tdata,
    input  logic [NUM_SRC*AXI4_RQ_TUSER_WIDTH-1:0] src_tuser,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0]          src_tkeep,
    input  logic [NUM_SRC-1:0]                     src_tlast,
    input  logic [NUM_SRC-1:0]                     src_tvalid,
    output logic [NUM_SRC-1:0]                     src_tready,
    output logic [C_DATA_WIDTH-1:0]                s_axis_rq_tdata,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]         s_axis_rq_tuser,
    output logic [KEEP_WIDTH-1:0]                  s_axis_rq_tkeep,
    output logic                                   s_axis_rq_tlast,
    output logic                                   s_axis_rq_tvalid,
    input  logic [3:0]                             s_axis_rq_tready,
    output logic [NUM_SRC-1:0]                     arb_grant,
    output logic [15:0]                            arb_pkt_cnt,
    output logic                                   arb_drop
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    arb_state_t         state;
    logic [NUM_SRC-1:0] grant;
    logic [PW-1:0]      g_idx;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      nxt_ptr;
    logic [15:0]        pkt_cnt;
    logic               drop;

    logic               busy;
    logic               act;
    logic               rdy;
    logic               acc;
    logic [NUM_SRC-1:0] pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PW      (PW)
    ) u_pick (
        .req   (src_tvalid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign busy = (state == ARB_BUSY);
    assign rdy  = |s_axis_rq_tready;
    // A down link blocks the handshake so no beat is lost mid-abort.
    assign act  = busy & user_lnk_up;
    assign acc  = s_axis_rq_tvalid & rdy;

    assign s_axis_rq_tvalid = act & src_tvalid[g_idx];
    assign src_tready       = (act & rdy) ? grant : '0;

    assign s_axis_rq_tdata = busy ?
        src_tdata[int'(g_idx)*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
    assign s_axis_rq_tuser = busy ?
        src_tuser[int'(g_idx)*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH] : '0;
    assign s_axis_rq_tkeep = busy ?
        src_tkeep[int'(g_idx)*KEEP_WIDTH +: KEEP_WIDTH] : '0;
    assign s_axis_rq_tlast = busy & src_tlast[g_idx];

    assign nxt_ptr = (g_idx == PW'(NUM_SRC - 1)) ? '0 : g_idx + PW'(1);

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            pkt_cnt <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (user_lnk_up && pick_any) begin
                        grant <= pick_gnt;
                        g_idx <= pick_idx;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!user_lnk_up) begin
                        rr_ptr <= nxt_ptr;
                        grant  <= '0;
                        drop   <= 1'b1;
                        state  <= ARB_IDLE;
                    end else if (acc && s_axis_rq_tlast) begin
                        rr_ptr  <= nxt_ptr;
                        pkt_cnt <= pkt_cnt + 16'd1;
                        grant   <= '0;
                        state   <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign arb_grant   = grant;
    assign arb_pkt_cnt = pkt_cnt;
    assign arb_drop    = drop;

endmodule

// File: tb/tb_rq_arbiter.sv
// Bench for rq_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_rq_arbiter;

    localparam int N = 4;
    localparam int W = 128;
    localparam int K = W / 32;
    localparam int U = 62;

    logic             user_clk = 1'b0;
    logic             user_reset_n;
    logic             user_lnk_up;
    logic [N*W-1:0]   src_tdata;
    logic [N*U-1:0]   src_tuser;
    logic [N*K-1:0]   src_tkeep;
    logic [N-1:0]     src_tlast;
    logic [N-1:0]     src_tvalid;
    logic [N-1:0]     src_tready;
    logic [W-1:0]     rq_tdata;
    logic [U-1:0]     rq_tuser;
    logic [K-1:0]     rq_tkeep;
    logic             rq_tlast;
    logic             rq_tvalid;
    logic [3:0]       rq_tready;
    logic [N-1:0]     arb_grant;
    logic [15:0]      arb_pkt_cnt;
    logic             arb_drop;

    always #5 user_clk = ~user_clk;

    rq_arbiter #(
        .NUM_SRC             (N),
        .C_DATA_WIDTH        (W),
        .KEEP_WIDTH          (K),
        .AXI4_RQ_TUSER_WIDTH (U)
    ) dut (
        .user_clk         (user_clk),
        .user_reset_n     (user_reset_n),
        .user_lnk_up      (user_lnk_up),
        .src_tdata        (src_tdata),
        .src_tuser        (src_tuser),
        .src_tkeep        (src_tkeep),
        .src_tlast        (src_tlast),
        .src_tvalid       (src_tvalid),
        .src_tready       (src_tready),
        .s_axis_rq_tdata  (rq_tdata),
        .s_axis_rq_tuser  (rq_tuser),
        .s_axis_rq_tkeep  (rq_tkeep),
        .s_axis_rq_tlast  (rq_tlast),
        .s_axis_rq_tvalid (rq_tvalid),
        .s_axis_rq_tready (rq_tready),
        .arb_grant        (arb_grant),
        .arb_pkt_cnt      (arb_pkt_cnt),
        .arb_drop         (arb_drop)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, where the search starts, packets done.
    int owner = -1;
    int mptr  = 0;
    int mcnt  = 0;
    bit mdrop = 1'b0;

    // Source models: packets pending, current length and beat, one-cycle gaps.
    int         npk  [N];
    int         plen [N];
    int         beat [N];
    bit         pause[N];
    logic [W-1:0] d  [N];
    logic [U-1:0] u  [N];
    int fix_len = 2;
    bit gaps    = 1'b0;

    int acc_src  = -1;
    bit acc_last = 1'b0;

    int trdy_cnt[N];
    int waitc   [N];
    int drop_cnt = 0;
    int gq[$];
    logic [N-1:0] prev_grant = '0;
    int saved;
    int lnk_hold = 0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_beat(int i);
        d[i] = {$urandom, $urandom, $urandom, $urandom};
        u[i] = U'({$urandom, $urandom});
    endtask

    task automatic start_pkt(int i);
        plen[i] = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
        beat[i] = 0;
        new_beat(i);
    endtask

    task automatic load(int i, int n);
        if (npk[i] == 0) begin
            npk[i] = n;
            start_pkt(i);
        end else begin
            npk[i] += n;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit l;
            l = (beat[i] == plen[i] - 1);
            src_tvalid[i]        = (npk[i] > 0) && !pause[i];
            src_tlast[i]         = l;
            src_tkeep[i*K +: K]  = l ? 4'h3 : 4'hF;
            src_tdata[i*W +: W]  = d[i];
            src_tuser[i*U +: U]  = u[i];
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] eg;
        logic [N-1:0] et;
        bit busy;
        bit ev;
        bit el;
        int o;
        o    = owner;
        busy = (o >= 0);
        eg   = '0;
        ev   = 1'b0;
        el   = 1'b0;
        if (busy) begin
            eg[o] = 1'b1;
            ev    = user_lnk_up && src_tvalid[o];
            el    = src_tlast[o];
        end
        et = (busy && user_lnk_up && (|rq_tready)) ? eg : '0;
        chk("grant", 128'(arb_grant), 128'(eg));
        chk("src_tready", 128'(src_tready), 128'(et));
        chk("tvalid", 128'(rq_tvalid), 128'(ev));
        chk("tdata", rq_tdata, busy ? d[o] : '0);
        chk("tuser", 128'(rq_tuser), busy ? 128'(u[o]) : '0);
        chk("tkeep", 128'(rq_tkeep), busy ? 128'(el ? 4'h3 : 4'hF) : '0);
        chk("tlast", 128'(rq_tlast), 128'(el));
        chk("pkt_cnt", 128'(arb_pkt_cnt), 128'(16'(mcnt)));
        chk("drop", 128'(arb_drop), 128'(mdrop));

        for (int i = 0; i < N; i++) trdy_cnt[i] += int'(src_tready[i]);
        drop_cnt += int'(arb_drop);
        if (arb_grant != '0 && prev_grant == '0) begin
            for (int j = 0; j < N; j++) begin
                if (arb_grant[j]) begin
                    gq.push_back(j);
                    chk("fairness", 128'(waitc[j] <= N - 1), 128'(1));
                    waitc[j] = 0;
                end else if (src_tvalid[j]) begin
                    waitc[j]++;
                end else begin
                    waitc[j] = 0;
                end
            end
        end
        prev_grant = arb_grant;

        acc_src  = -1;
        acc_last = 1'b0;
        if (ev && (|rq_tready)) begin
            acc_src  = o;
            acc_last = el;
        end
    endtask

    task automatic update();
        int dropped;
        dropped = -1;
        mdrop   = 1'b0;
        if (owner < 0) begin
            if (user_lnk_up && (|src_tvalid)) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (mptr + k) % N;
                    if (src_tvalid[j]) begin
                        owner = j;
                        break;
                    end
                end
            end
        end else if (!user_lnk_up) begin
            dropped = owner;
            mptr    = (owner + 1) % N;
            owner   = -1;
            mdrop   = 1'b1;
        end else if (acc_src >= 0 && acc_last) begin
            mptr  = (owner + 1) % N;
            mcnt  = (mcnt + 1) % 65536;
            owner = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (i == dropped) begin
                npk[i]--;
                pause[i] = 1'b0;
                if (npk[i] > 0) start_pkt(i);
            end else if (pause[i]) begin
                pause[i] = 1'b0;
            end else if (i == acc_src) begin
                if (acc_last) begin
                    npk[i]--;
                    if (npk[i] > 0) start_pkt(i);
                end else begin
                    beat[i]++;
                    new_beat(i);
                end
                pause[i] = gaps && ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic step();
        drive();
        #4;
        check_cycle();
        @(posedge user_clk);
        update();
        #1;
    endtask

    function automatic bit all_idle();
        bit r;
        r = (owner < 0);
        for (int i = 0; i < N; i++) if (npk[i] != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(int budget);
        for (int c = 0; c < budget && !all_idle(); c++) step();
        chk("drain", 128'(all_idle()), 128'(1));
        step();
    endtask

    task automatic model_reset();
        owner      = -1;
        mptr       = 0;
        mcnt       = 0;
        mdrop      = 1'b0;
        prev_grant = '0;
        for (int i = 0; i < N; i++) begin
            npk[i]   = 0;
            plen[i]  = 1;
            beat[i]  = 0;
            pause[i] = 1'b0;
            d[i]     = '0;
            u[i]     = '0;
            waitc[i] = 0;
        end
    endtask

    initial begin
        user_reset_n = 1'b0;
        user_lnk_up  = 1'b1;
        rq_tready    = 4'h0;
        model_reset();
        drive();
        #12;
        chk("rst_grant", 128'(arb_grant), 128'(0));
        chk("rst_tvalid", 128'(rq_tvalid), 128'(0));
        chk("rst_pkt_cnt", 128'(arb_pkt_cnt), 128'(0));
        chk("rst_tdata", rq_tdata, 128'(0));
        @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
        rq_tready    = 4'hF;

        // Contention from reset pointer 0: order must be 0, 2, 3.
        fix_len = 2;
        gq.delete();
        load(0, 1);
        load(2, 1);
        load(3, 1);
        drain(40);
        chk("cont_n", 128'(gq.size()), 128'(3));
        if (gq.size() == 3) begin
            chk("cont_0", 128'(gq[0]), 128'(0));
            chk("cont_1", 128'(gq[1]), 128'(2));
            chk("cont_2", 128'(gq[2]), 128'(3));
        end

        // Single 2-beat packet from source 1.
        for (int i = 0; i < N; i++) trdy_cnt[i] = 0;
        saved = mcnt;
        load(1, 1);
        drain(20);
        chk("single_trdy1", 128'(trdy_cnt[1]), 128'(2));
        chk("single_cnt", 128'(arb_pkt_cnt), 128'(16'(saved + 1)));

        // Backpressure on source 2 mid-packet while source 0 waits.
        fix_len = 3;
        gq.delete();
        load(2, 1);
        for (int c = 0; c < 10 && !(owner == 2 && beat[2] == 1); c++) step();
        chk("bp_start", 128'(owner == 2 && beat[2] == 1), 128'(1));
        rq_tready = 4'h0;
        load(0, 1);
        repeat (5) step();
        rq_tready = 4'h2;
        drain(40);
        chk("bp_n", 128'(gq.size()), 128'(2));
        if (gq.size() == 2) begin
            chk("bp_0", 128'(gq[0]), 128'(2));
            chk("bp_1", 128'(gq[1]), 128'(0));
        end
        rq_tready = 4'hF;

        // Source 0 streams 1-beat packets; source 3 must get in promptly.
        fix_len = 1;
        gq.delete();
        load(0, 12);
        step();
        step();
        load(3, 1);
        drain(100);
        chk("fair_src3", 128'(gq.size() > 0 && (3 inside {gq})), 128'(1));

        // Link drops after the first beat of a 3-beat source 1 packet.
        fix_len  = 3;
        drop_cnt = 0;
        load(1, 1);
        for (int c = 0; c < 10 && !(owner == 1 && beat[1] == 1); c++) step();
        chk("drop_start", 128'(owner == 1 && beat[1] == 1), 128'(1));
        saved       = mcnt;
        user_lnk_up = 1'b0;
        load(2, 1);
        repeat (3) begin
            step();
            chk("down_tready", 128'(src_tready), 128'(0));
        end
        chk("drop_cnt_hold", 128'(arb_pkt_cnt), 128'(16'(saved)));
        chk("drop_pulses", 128'(drop_cnt), 128'(1));
        gq.delete();
        load(1, 1);
        user_lnk_up = 1'b1;
        drain(40);
        chk("relink_n", 128'(gq.size()), 128'(2));
        if (gq.size() > 0) chk("relink_first", 128'(gq[0]), 128'(2));

        // Asynchronous reset between edges in the middle of a packet.
        load(2, 1);
        for (int c = 0; c < 10 && !(owner == 2 && beat[2] == 1); c++) step();
        chk("ar_start", 128'(owner == 2 && beat[2] == 1), 128'(1));
        #2;
        user_reset_n = 1'b0;
        #1;
        chk("ar_grant", 128'(arb_grant), 128'(0));
        chk("ar_tvalid", 128'(rq_tvalid), 128'(0));
        chk("ar_tready", 128'(src_tready), 128'(0));
        chk("ar_cnt", 128'(arb_pkt_cnt), 128'(0));
        chk("ar_tdata", rq_tdata, 128'(0));
        model_reset();
        drive();
        @(posedge user_clk);
        @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
        gq.delete();
        fix_len = 2;
        load(3, 1);
        load(0, 1);
        drain(40);
        if (gq.size() > 0) chk("ar_first", 128'(gq[0]), 128'(0));
        chk("ar_n", 128'(gq.size()), 128'(2));

        // Random traffic, backpressure, gaps and occasional link drops.
        fix_len = 0;
        gaps    = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rq_tready = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (lnk_hold > 0) begin
                lnk_hold--;
                user_lnk_up = 1'b0;
            end else begin
                user_lnk_up = 1'b1;
                if ($urandom_range(0, 299) == 0) begin
                    lnk_hold    = int'($urandom_range(0, 2));
                    user_lnk_up = 1'b0;
                end
            end
            for (int i = 0; i < N; i++)
                if (npk[i] == 0 && $urandom_range(0, 7) == 0)
                    load(i, int'($urandom_range(1, 3)));
            step();
        end
        user_lnk_up = 1'b1;
        rq_tready   = 4'hF;
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
